multi_tick_gen: RTL and testbench

Parametrised, multi-channel programmable tick generator: the successor to the single 28-bit up counter used to derive slow enables from the 100 MHz board clock. Each channel divides the clock by its own run-time period, emits a one-cycle tick, a 50 % square wave and its live count. Channels run in periodic or one-shot mode, and a period can be changed without glitches. It sits beside the top level and feeds PWM, debounce, sampling and timeout logic.

---
 rtl/tick_gen_pkg.sv | 20 ++
 rtl/tick_channel.sv | 139 +++++++++++++
 rtl/multi_tick_gen.sv | 50 +++++
 tb/tb_multi_tick_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and types for the programmable tick generator.
//   DEFAULT_WIDTH   default counter/period width per channel
//   tickMode_e      per-channel run mode (periodic or one-shot)
//   TICKS_*         tick periods in 100 MHz board-clock cycles
package tick_gen_pkg;

  localparam int unsigned DEFAULT_WIDTH = 28;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tickMode_e;

  // Periods for common slow enables derived from the 100 MHz board clock
  localparam int unsigned TICKS_1HZ    = 100_000_000;
  localparam int unsigned TICKS_100HZ  = 1_000_000;
  localparam int unsigned TICKS_20KHZ  = 5_000;
  localparam int unsigned TICKS_100KHZ = 1_000;

endpackage : tick_gen_pkg

// File: rtl/tick_channel.sv
// tick_channel: one programmable divider channel.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   period        new period value, captured on load
//   load          strobe: write shadow period (and active period when safe)
//   enable        run/pause
//   oneshot       1 = one-shot mode, 0 = periodic mode
//   start         strobe: arm one-shot, or resync phase in periodic mode
//   tick          one-cycle pulse on each period wrap
//   square        toggles on every tick (50 % duty at clock/(2P))
//   busy          channel is actively counting
//   count         live counter value
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] period,
  input  logic             load,
  input  logic             enable,
  input  logic             oneshot,
  input  logic             start,
  output logic             tick,
  output logic             square,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] activePeriod;
  logic [WIDTH-1:0] shadowPeriod;
  logic             armed;

  logic [WIDTH-1:0] activeNext;
  logic [WIDTH-1:0] shadowNext;
  logic [WIDTH-1:0] countNext;
  logic             armedNext;
  logic             tickNext;
  logic             squareNext;
  logic             busyNext;

  tickMode_e        mode;
  logic             idle;
  logic             atTerminal;
  logic             running;
  logic             wrap;

  // Status decode of the current state
  always_comb begin
    mode       = tickMode_e'(oneshot);
    idle       = (activePeriod == '0);
    // A-1 only matters when A != 0; idle blocks running in that case
    atTerminal = (count == (activePeriod - WIDTH'(1)));
    running    = enable && !idle && ((mode == MODE_PERIODIC) || armed);
    wrap       = running && atTerminal;
  end

  // Next-state and next-output logic
  always_comb begin
    activeNext = activePeriod;
    shadowNext = shadowPeriod;
    countNext  = count;
    armedNext  = armed;
    tickNext   = 1'b0;
    squareNext = square;
    busyNext   = 1'b0;

    if (running) begin
      if (wrap) begin
        countNext  = '0;
        tickNext   = 1'b1;
        squareNext = ~square;
        activeNext = shadowPeriod;
      end else begin
        countNext = count + WIDTH'(1);
      end
    end

    // While counting periodically, keep armed set so that a switch to
    // one-shot finishes the period in flight and then stops.
    if (mode == MODE_PERIODIC) begin
      if (running) begin
        armedNext = 1'b1;
      end
    end else if (wrap) begin
      armedNext = 1'b0;
    end

    if (start) begin
      countNext = '0;
      if (mode == MODE_PERIODIC) begin
        // Phase resync: restart the period silently
        squareNext = 1'b0;
        tickNext   = 1'b0;
      end else begin
        // Arm, or re-arm on a coincident wrap (tick still fires)
        armedNext = 1'b1;
      end
    end

    if (load) begin
      shadowNext = period;
      // A counting channel defers the new period to its next wrap
      if (!busy || wrap) begin
        activeNext = period;
      end
    end

    // Zero period means idle: counter parked at 0
    if (activeNext == '0) begin
      countNext = '0;
    end

    busyNext = enable && (activeNext != '0) &&
               ((mode == MODE_PERIODIC) || armedNext);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      activePeriod <= '0;
      shadowPeriod <= '0;
      count        <= '0;
      armed        <= 1'b0;
      tick         <= 1'b0;
      square       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      activePeriod <= activeNext;
      shadowPeriod <= shadowNext;
      count        <= countNext;
      armed        <= armedNext;
      tick         <= tickNext;
      square       <= squareNext;
      busy         <= busyNext;
    end
  end

endmodule : tick_channel

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: CHANNELS independent programmable tick generators.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   period_in     packed periods, channel n at [n*WIDTH +: WIDTH]
//   load          per-channel period load strobe
//   enable        per-channel run/pause
//   oneshot       per-channel mode select (1 = one-shot)
//   start         per-channel arm / phase-resync strobe
//   tick          per-channel one-cycle wrap pulse
//   square        per-channel 50 % square wave
//   busy          per-channel counting flag
//   count         packed live counters, same layout as period_in
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS-1:0]       start,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       square,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  // One divider per channel, sliced from the packed buses
  for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : gChannel
    tick_channel #(
      .WIDTH (WIDTH)
    ) uChannel (
      .clock   (clock),
      .reset   (reset),
      .period  (period_in[ch*WIDTH +: WIDTH]),
      .load    (load[ch]),
      .enable  (enable[ch]),
      .oneshot (oneshot[ch]),
      .start   (start[ch]),
      .tick    (tick[ch]),
      .square  (square[ch]),
      .busy    (busy[ch]),
      .count   (count[ch*WIDTH +: WIDTH])
    );
  end

endmodule : multi_tick_gen

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed self-checking bench for multi_tick_gen
// (WIDTH=4 so the all-ones period is reachable).
module tb_multi_tick_gen;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] period_in;
  logic [N-1:0]   load;
  logic [N-1:0]   enable;
  logic [N-1:0]   oneshot;
  logic [N-1:0]   start;
  logic [N-1:0]   tick;
  logic [N-1:0]   square;
  logic [N-1:0]   busy;
  logic [N*W-1:0] count;

  int checks = 0;
  int passes = 0;

  multi_tick_gen #(
    .WIDTH    (W),
    .CHANNELS (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .period_in (period_in),
    .load      (load),
    .enable    (enable),
    .oneshot   (oneshot),
    .start     (start),
    .tick      (tick),
    .square    (square),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  task automatic doReset();
    reset = 1'b1; load = '0; enable = '0; oneshot = '0; start = '0; period_in = '0;
    step(1);
    reset = 1'b0;
  endtask

  int exp2 [14] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0, 1, 2, 0};
  int b3   [5]  = '{1, 1, 1, 0, 0};
  int c3   [5]  = '{1, 2, 3, 0, 0};
  int t3   [5]  = '{0, 0, 0, 1, 0};
  int c5   [25] = '{1, 2, 3, 4, 5, 0, 1, 2, 2, 2, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 0, 1};

  initial begin
    reset = 1'b1; load = '0; enable = '0; oneshot = '0; start = '0; period_in = '0;
    step(2);
    checkEq("reset tick",   tick,   0);
    checkEq("reset square", square, 0);
    checkEq("reset busy",   busy,   0);
    checkEq("reset count",  count,  0);
    reset = 1'b0;

    // Periodic P=5 on channel 0, others silent
    period_in[3:0] = 4'd5; load[0] = 1'b1; enable[0] = 1'b1;
    step(1);
    load = '0;
    checkEq("p5 busy after load",  busy[0], 1);
    checkEq("p5 count after load", cnt(0), 0);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      checkEq($sformatf("p5 count e%0d", i),  cnt(0), i % 5);
      checkEq($sformatf("p5 tick e%0d", i),   tick[0], (i % 5) == 0);
      checkEq($sformatf("p5 square e%0d", i), square[0], (i >= 5) && (i < 10));
      checkEq($sformatf("p5 others e%0d", i), {tick[3:1], busy[3:1]}, 0);
    end

    // Periodic P=8, reload 3 at C=2: finish 8, then 3-cycle periods
    doReset();
    period_in[7:4] = 4'd8; load[1] = 1'b1; enable[1] = 1'b1;
    step(1);
    load = '0;
    checkEq("reload busy", busy[1], 1);
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        period_in[7:4] = 4'd3; load[1] = 1'b1;
      end
      step(1);
      load = '0;
      checkEq($sformatf("reload count e%0d", i + 1), cnt(1), exp2[i]);
      checkEq($sformatf("reload tick e%0d", i + 1),  tick[1], exp2[i] == 0);
    end

    // One-shot P=4 on channel 2
    doReset();
    oneshot[2] = 1'b1; enable[2] = 1'b1; period_in[11:8] = 4'd4; load[2] = 1'b1;
    step(1);
    load = '0;
    checkEq("os unarmed busy", busy[2], 0);
    step(2);
    checkEq("os unarmed count", cnt(2), 0);
    checkEq("os unarmed tick",  tick[2], 0);
    start[2] = 1'b1;
    step(1);
    start = '0;
    checkEq("os start busy",  busy[2], 1);
    checkEq("os start count", cnt(2), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkEq($sformatf("os busy s%0d", i + 1),  busy[2], b3[i]);
      checkEq($sformatf("os count s%0d", i + 1), cnt(2), c3[i]);
      checkEq($sformatf("os tick s%0d", i + 1),  tick[2], t3[i]);
    end
    start[2] = 1'b1;
    step(1);
    start = '0;
    step(2);
    checkEq("os mid count", cnt(2), 2);
    start[2] = 1'b1;
    step(1);
    start = '0;
    checkEq("os restart count", cnt(2), 0);
    checkEq("os restart busy",  busy[2], 1);
    checkEq("os restart tick",  tick[2], 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkEq($sformatf("os2 busy s%0d", i + 1),  busy[2], b3[i]);
      checkEq($sformatf("os2 count s%0d", i + 1), cnt(2), c3[i]);
      checkEq($sformatf("os2 tick s%0d", i + 1),  tick[2], t3[i]);
    end

    // Corner periods on channel 3: 0, 1, 15
    doReset();
    enable[3] = 1'b1; period_in[15:12] = 4'd0; load[3] = 1'b1;
    step(1);
    load = '0;
    step(2);
    checkEq("p0 busy",   busy[3], 0);
    checkEq("p0 tick",   tick[3], 0);
    checkEq("p0 count",  cnt(3), 0);
    checkEq("p0 square", square[3], 0);
    period_in[15:12] = 4'd1; load[3] = 1'b1;
    step(1);
    load = '0;
    checkEq("p1 busy", busy[3], 1);
    checkEq("p1 tick", tick[3], 0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checkEq($sformatf("p1 tick e%0d", i),   tick[3], 1);
      checkEq($sformatf("p1 square e%0d", i), square[3], i % 2);
      checkEq($sformatf("p1 count e%0d", i),  cnt(3), 0);
    end
    doReset();
    enable[3] = 1'b1; period_in[15:12] = 4'd15; load[3] = 1'b1;
    step(1);
    load = '0;
    for (int i = 1; i <= 31; i++) begin
      step(1);
      checkEq($sformatf("p15 count e%0d", i), cnt(3), i % 15);
      checkEq($sformatf("p15 tick e%0d", i),  tick[3], (i % 15) == 0);
    end

    // Pause for 3 cycles at C=2, then periodic resync via start
    doReset();
    period_in[3:0] = 4'd6; load[0] = 1'b1; enable[0] = 1'b1;
    step(1);
    load = '0;
    for (int i = 1; i <= 25; i++) begin
      enable[0] = !((i >= 9) && (i <= 11));
      start[0]  = (i == 24);
      step(1);
      start = '0;
      checkEq($sformatf("pause count e%0d", i),  cnt(0), c5[i-1]);
      checkEq($sformatf("pause tick e%0d", i),   tick[0], (i == 6) || (i == 15) || (i == 21));
      checkEq($sformatf("pause square e%0d", i), square[0],
              ((i >= 6) && (i <= 14)) || ((i >= 21) && (i <= 23)));
      checkEq($sformatf("pause busy e%0d", i),   busy[0], !((i >= 9) && (i <= 11)));
    end

    // Reset mid-period on all channels
    doReset();
    period_in = {4'd7, 4'd5, 4'd3, 4'd9}; load = '1; enable = '1;
    step(1);
    load = '0;
    step(4);
    checkEq("pre-reset count",  count, 16'h4414);
    checkEq("pre-reset square", square, 4'b0010);
    checkEq("pre-reset busy",   busy, 4'hF);
    reset = 1'b1;
    step(1);
    checkEq("mid reset count",  count, 0);
    checkEq("mid reset tick",   tick, 0);
    checkEq("mid reset square", square, 0);
    checkEq("mid reset busy",   busy, 0);
    reset = 1'b0;
    step(3);
    checkEq("post reset count", count, 0);
    checkEq("post reset busy",  busy, 0);
    checkEq("post reset tick",  tick, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_multi_tick_gen
